// File: rtl/ads_spi_master.sv
// ---------------------------------------------------------------------------
// ads_spi_master
//
// SPI master for the four-channel ADS front end. After ads_en goes high it
// sends the configuration frames (auto-sequence enable, four range writes),
// then an auto-sequence reset, then NO_OP frames for as long as ads_en stays
// high. The word shifted in during the second half of each frame is
// published on receive_data together with the frame index on pkg_num.
//
// Parameters
//   CLK_DIV    clk cycles per SCLK half-period (H), 2..255
//   CS_GAP     clk cycles ads_cs stays high between frames, >= 4
//   RANGE_CODE byte written to the range registers of channels 0-3
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ads_en       run enable (level)
//   ads_sdo      serial data from the ADC
//   ads_cs       chip select, active low
//   ads_sclk     serial clock, idles low
//   ads_sdi      serial data to the ADC
//   receive_data word captured in the last completed frame
//   pkg_num      index of the frame whose data is on receive_data
//   busy         high from CS fall until the end of the inter-frame gap
// ---------------------------------------------------------------------------
module ads_spi_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_GAP     = 8,
  parameter logic [7:0]  RANGE_CODE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ads_en,
  input  logic        ads_sdo,
  output logic        ads_cs,
  output logic        ads_sclk,
  output logic        ads_sdi,
  output logic [15:0] receive_data,
  output logic [15:0] pkg_num,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // One counter times both SCLK half-periods and the CS gap, so it is sized
  // for whichever of the two is longer.
  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pulse_q, pulse_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             sdi_q, sdi_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [15:0]      pkg_q, pkg_d;
  logic             busy_q, busy_d;

  logic [15:0]      fcntInc;
  logic [15:0]      cmdSel;
  logic [4:0]       nextPulse;

  // Command table indexed by frame number.
  function automatic logic [15:0] cmdFor(input logic [15:0] idx);
    logic [15:0] c;
    case (idx)
      16'd0:   c = 16'h030F;
      16'd1:   c = {8'h0B, RANGE_CODE};
      16'd2:   c = {8'h0D, RANGE_CODE};
      16'd3:   c = {8'h0F, RANGE_CODE};
      16'd4:   c = {8'h11, RANGE_CODE};
      16'd5:   c = 16'hA000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Next-state and output logic. A frame is SETUP (H), 32 SCLK pulses
  // (2H each), HOLD (H), then the CS-high gap. The command is latched on
  // entry to SETUP; coming out of GAP that is the command of the
  // already-incremented frame index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = pulse_q;
    cmd_d     = cmd_q;
    shreg_d   = shreg_q;
    fcnt_d    = fcnt_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    sdi_d     = sdi_q;
    rdata_d   = rdata_q;
    pkg_d     = pkg_q;
    busy_d    = busy_q;
    fcntInc   = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
    cmdSel    = cmdFor((state_q == GAP) ? fcntInc : fcnt_q);
    nextPulse = pulse_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (ads_en) begin
          state_d = SETUP;
          cnt_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cmd_d   = cmdSel;
          sdi_d   = cmdSel[15];
        end
      end

      SETUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == H_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          pulse_d = '0;
          sclk_d  = 1'b1;
          sdi_d   = cmd_q[15];
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == H_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: pulses 17..32 (index 16..31) capture SDO.
            sclk_d = 1'b0;
            if (pulse_q[4]) begin
              shreg_d = {shreg_q[14:0], ads_sdo};
            end
          end else if (pulse_q == 5'd31) begin
            state_d = HOLD;
          end else begin
            // Rising edge of the next pulse: SDI moves only here, carrying
            // the command during the first 16 pulses and zeros after.
            pulse_d = nextPulse;
            sclk_d  = 1'b1;
            sdi_d   = nextPulse[4] ? 1'b0 : cmd_q[4'd15 - nextPulse[3:0]];
          end
        end
      end

      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == H_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_d    = 1'b1;
          rdata_d = shreg_q;
          pkg_d   = fcnt_q;
        end
      end

      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (ads_en) begin
            state_d = SETUP;
            fcnt_d  = fcntInc;
            cs_d    = 1'b0;
            cmd_d   = cmdSel;
            sdi_d   = cmdSel[15];
          end else begin
            state_d = IDLE;
            fcnt_d  = '0;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      cmd_q   <= '0;
      shreg_q <= '0;
      fcnt_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      rdata_q <= '0;
      pkg_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      cmd_q   <= cmd_d;
      shreg_q <= shreg_d;
      fcnt_q  <= fcnt_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      rdata_q <= rdata_d;
      pkg_q   <= pkg_d;
      busy_q  <= busy_d;
    end
  end

  assign ads_cs       = cs_q;
  assign ads_sclk     = sclk_q;
  assign ads_sdi      = sdi_q;
  assign receive_data = rdata_q;
  assign pkg_num      = pkg_q;
  assign busy         = busy_q;

endmodule
